// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register file.
// Optional write-through forwarding: REG_FILE_BYPASS_EN.
package reg_file_pkg;

   localparam int RF_WIDTH  = 32;
   localparam int RF_DEPTH  = 32;
   localparam int RF_NUM_RD = 2;
   localparam int RF_AW     = $clog2(RF_DEPTH);

   typedef logic [RF_AW-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: mux, zero register, optional bypass.
// Forwarding of the in-flight write enabled by REG_FILE_BYPASS_EN.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0][WIDTH-1:0] i_regs,
   input  logic [DEPTH-1:0]            i_pend,
   input  logic                        i_wr,
   input  logic [AW-1:0]               i_waddr,
   input  logic [WIDTH-1:0]            i_wdata,
   input  logic                        i_mk,
   input  logic [AW-1:0]               i_mark_addr,
   input  logic [AW-1:0]               i_raddr,
   output logic [WIDTH-1:0]            o_rdata,
   output logic                        o_rbusy
);

`ifndef REG_FILE_BYPASS_EN
   logic w_unused;
   assign w_unused = ^{i_wr, i_waddr, i_wdata, i_mk, i_mark_addr};
`endif

   always_comb begin
      o_rdata = i_regs[i_raddr];
      o_rbusy = i_pend[i_raddr];
`ifdef REG_FILE_BYPASS_EN
      // i_wr already excludes address 0
      if (i_wr && (i_raddr == i_waddr)) begin
         o_rdata = i_wdata;
         o_rbusy = i_mk && (i_mark_addr == i_waddr);
      end
`endif
      if (i_raddr == '0) begin
         o_rdata = '0;
         o_rbusy = 1'b0;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Register file with per-register pending scoreboard and NUM_RD read ports.
// Define REG_FILE_BYPASS_EN for same-cycle write-through on reads.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int DEPTH  = RF_DEPTH,
   parameter int NUM_RD = RF_NUM_RD,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         res,
   input  logic                         we,
   input  logic [AW-1:0]                waddr,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         mark,
   input  logic [AW-1:0]                mark_addr,
   input  logic [NUM_RD-1:0][AW-1:0]    raddr,
   output logic [NUM_RD-1:0][WIDTH-1:0] rdata,
   output logic [NUM_RD-1:0]            rbusy
);

   logic [DEPTH-1:0][WIDTH-1:0] r_regs;
   logic [DEPTH-1:0]            r_pend;
   logic                        w_wr;
   logic                        w_mk;

   assign w_wr = we && (waddr != '0);
   assign w_mk = mark && (mark_addr != '0);

   // mark is applied after the write clear so a same-address set wins
   always_ff @(posedge clk) begin
      if (!res) begin
         r_regs <= '0;
         r_pend <= '0;
      end else begin
         if (w_wr) begin
            r_regs[waddr] <= wdata;
            r_pend[waddr] <= 1'b0;
         end
         if (w_mk) r_pend[mark_addr] <= 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      reg_file_rd_port #(
         .WIDTH(WIDTH),
         .DEPTH(DEPTH)
      ) u_rd (
         .i_regs     (r_regs),
         .i_pend     (r_pend),
         .i_wr       (w_wr),
         .i_waddr    (waddr),
         .i_wdata    (wdata),
         .i_mk       (w_mk),
         .i_mark_addr(mark_addr),
         .i_raddr    (raddr[g]),
         .o_rdata    (rdata[g]),
         .o_rbusy    (rbusy[g])
      );
   end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: default instance plus an 8x4, 3-port one.
// Expectations follow REG_FILE_BYPASS_EN when it is defined.
module tb_reg_file;
   import reg_file_pkg::*;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic res;

   logic                          we;
   rf_addr_t                      waddr;
   logic [31:0]                   wdata;
   logic                          mark;
   rf_addr_t                      mark_addr;
   rf_addr_t [RF_NUM_RD-1:0]      raddr;
   logic [RF_NUM_RD-1:0][31:0]    rdata;
   logic [RF_NUM_RD-1:0]          rbusy;

   logic            s_we;
   logic [1:0]      s_waddr;
   logic [7:0]      s_wdata;
   logic            s_mark;
   logic [1:0]      s_mark_addr;
   logic [2:0][1:0] s_raddr;
   logic [2:0][7:0] s_rdata;
   logic [2:0]      s_rbusy;

   reg_file u_dut (
      .clk      (clk),
      .res      (res),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .mark     (mark),
      .mark_addr(mark_addr),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy)
   );

   reg_file #(
      .WIDTH (8),
      .DEPTH (4),
      .NUM_RD(3)
   ) u_small (
      .clk      (clk),
      .res      (res),
      .we       (s_we),
      .waddr    (s_waddr),
      .wdata    (s_wdata),
      .mark     (s_mark),
      .mark_addr(s_mark_addr),
      .raddr    (s_raddr),
      .rdata    (s_rdata),
      .rbusy    (s_rbusy)
   );

   typedef struct {
      int          dut;
      int          port;
      logic [31:0] d;
      logic        b;
      string       nm;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: outputs are combinational, sampled mid-cycle
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t        e;
         logic [31:0] ad;
         logic        ab;
         e = q.pop_front();
         if (e.dut == 0) begin
            ad = rdata[e.port];
            ab = rbusy[e.port];
         end else begin
            ad = 32'(s_rdata[e.port]);
            ab = s_rbusy[e.port];
         end
         total++;
         if (ad !== e.d || ab !== e.b) begin
            bad++;
            $display("FAIL %s: port%0d got data=%h busy=%b need data=%h busy=%b",
                     e.nm, e.port, ad, ab, e.d, e.b);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we     = 1'b0;
      mark   = 1'b0;
      s_we   = 1'b0;
      s_mark = 1'b0;
   endtask

   task automatic rd(input int dut, input int port, input int addr,
                     input logic [31:0] d, input logic b, input string nm);
      exp_t e;
      if (dut == 0) raddr[port] = rf_addr_t'(addr);
      else s_raddr[port] = 2'(addr);
      e.dut  = dut;
      e.port = port;
      e.d    = d;
      e.b    = b;
      e.nm   = nm;
      q.push_back(e);
   endtask

   task automatic wr(input int addr, input logic [31:0] d);
      we    = 1'b1;
      waddr = rf_addr_t'(addr);
      wdata = d;
   endtask

   task automatic mk(input int addr);
      mark      = 1'b1;
      mark_addr = rf_addr_t'(addr);
   endtask

   initial begin
      res = 1'b0;
      idle();
      waddr = '0; wdata = '0; mark_addr = '0; raddr = '0;
      s_waddr = '0; s_wdata = '0; s_mark_addr = '0; s_raddr = '0;
      tick();
      tick();
      res = 1'b1;

      // preload, then reset with a write pending that must be discarded
      wr(5, 32'h11); tick();
      wr(31, 32'h31); mk(6); tick();
      s_we = 1'b1; s_waddr = 2'd1; s_wdata = 8'h5A; s_mark = 1'b1; s_mark_addr = 2'd2;
      idle(); tick();
      res = 1'b0; wr(4, 32'h44); mk(4); tick();
      res = 1'b1; idle();
      for (int a = 0; a < RF_DEPTH; a++) begin
         rd(0, 0, a, 32'h0, 1'b0, "reset_p0");
         rd(0, 1, a, 32'h0, 1'b0, "reset_p1");
         if (a < 4) rd(1, 0, a, 32'h0, 1'b0, "reset_small");
         tick();
      end

      wr(5, 32'hDEADBEEF); tick();
      idle();
      rd(0, 0, 5, 32'hDEADBEEF, 1'b0, "wr5_p0");
      rd(0, 1, 5, 32'hDEADBEEF, 1'b0, "wr5_p1");
      tick();

      wr(0, 32'hFFFFFFFF); mk(0); tick();
      idle();
      rd(0, 0, 0, 32'h0, 1'b0, "zero_p0");
      rd(0, 1, 0, 32'h0, 1'b0, "zero_p1");
      tick();

      mk(7); tick();
      idle();
      rd(0, 0, 7, 32'h0, 1'b1, "mark7");
      tick();
      wr(7, 32'h12);
      rd(0, 0, 7, BYP ? 32'h12 : 32'h0, !BYP, "wr7_same_cycle");
      tick();
      idle();
      rd(0, 0, 7, 32'h12, 1'b0, "wr7_clears");
      tick();
      wr(7, 32'h34); mk(7);
      rd(0, 1, 7, BYP ? 32'h34 : 32'h12, BYP, "mkwr7_same_cycle");
      tick();
      idle();
      rd(0, 1, 7, 32'h34, 1'b1, "mkwr7_set_wins");
      tick();

      wr(9, 32'h99); mk(8); tick();
      idle();
      rd(0, 0, 8, 32'h0, 1'b1, "diff_mark8");
      rd(0, 1, 9, 32'h99, 1'b0, "diff_wr9");
      tick();

      wr(3, 32'hA5A5A5A5);
      rd(0, 0, 3, BYP ? 32'hA5A5A5A5 : 32'h0, 1'b0, "bypass3");
      tick();
      idle();
      rd(0, 0, 3, 32'hA5A5A5A5, 1'b0, "wr3_after");
      tick();

      res = 1'b0; wr(9, 32'h77); tick();
      res = 1'b1; idle();
      rd(0, 0, 9, 32'h0, 1'b0, "reset_wr9");
      rd(0, 1, 5, 32'h0, 1'b0, "reset_r5");
      wr(10, 32'hAB); tick();
      idle();
      rd(0, 0, 10, 32'hAB, 1'b0, "first_wr_after_reset");
      tick();

      s_we = 1'b1; s_waddr = 2'd2; s_wdata = 8'hEF; tick();
      idle();
      rd(1, 0, 2, 32'hEF, 1'b0, "s_wr2_p0");
      rd(1, 1, 2, 32'hEF, 1'b0, "s_wr2_p1");
      rd(1, 2, 2, 32'hEF, 1'b0, "s_wr2_p2");
      tick();
      s_we = 1'b1; s_waddr = 2'd0; s_wdata = 8'hFF;
      s_mark = 1'b1; s_mark_addr = 2'd0; tick();
      idle();
      rd(1, 0, 0, 32'h0, 1'b0, "s_zero");
      tick();
      s_mark = 1'b1; s_mark_addr = 2'd3; tick();
      idle();
      rd(1, 2, 3, 32'h0, 1'b1, "s_mark3");
      tick();
      s_we = 1'b1; s_waddr = 2'd3; s_wdata = 8'h12; tick();
      idle();
      rd(1, 1, 3, 32'h12, 1'b0, "s_wr3_clears");
      tick();
      s_we = 1'b1; s_waddr = 2'd3; s_wdata = 8'h34;
      s_mark = 1'b1; s_mark_addr = 2'd3; tick();
      idle();
      rd(1, 0, 3, 32'h34, 1'b1, "s_mkwr3_set_wins");
      tick();

      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d left, need 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter DEPTH, default 32, number of registers; power of two, at least 2.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports.
REQ-004 Derived AW = $clog2(DEPTH), address width.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 res  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  AW  write address.
REQ-009 wdata  input  WIDTH  write data.
REQ-010 mark  input  1  scoreboard set request: flags a register as pending a write.
REQ-011 mark_addr  input  AW  register to flag.
REQ-012 raddr  input  NUM_RD x AW  read addresses, one per port.
REQ-013 rdata  output  NUM_RD x WIDTH  read data, one per port.
REQ-014 rbusy  output  NUM_RD x 1  pending flag of the addressed register, one per port.

Function
REQ-015 Storage: DEPTH x WIDTH registers, plus a DEPTH-bit pending vector.
REQ-016 Write: when we=1 and waddr!=0, reg[waddr] <= wdata at the next posedge; otherwise unchanged.
REQ-017 Register 0 is hardwired zero: writes to it are discarded, reads return 0, and its pending bit is always 0.
REQ-018 Reads are combinational: rdata[i] = reg[raddr[i]] with zero added latency; ports are fully independent, and any number may address the same register.
REQ-019 Pending set: mark=1 and mark_addr!=0 sets pend[mark_addr] at the next posedge.
REQ-020 Pending clear: we=1 and waddr!=0 clears pend[waddr] at the next posedge.
REQ-021 Simultaneous mark and write to the same address: set wins (pend=1) and the data is still written.
REQ-022 Simultaneous mark and write to different addresses: both take effect.
REQ-023 rbusy[i] = pend[raddr[i]], combinational.
REQ-024 All address inputs are in range by construction; there is no out-of-range handling.

Reset
REQ-025 res=0 at a posedge clears every register to 0 and every pending bit to 0, overriding we and mark in that cycle.
REQ-026 Reset asserted mid-operation discards any in-flight write or mark; the first write is accepted at the first posedge with res=1.
REQ-027 Output values under reset follow from REQ-018/023: rdata all 0 and rbusy all 0 one cycle after reset is sampled.

Configuration
REQ-028 Macro REG_FILE_BYPASS_EN, when defined: if we=1, waddr!=0 and raddr[i]==waddr, rdata[i]=wdata and rbusy[i]=0 in the same cycle (write-through forwarding). rbusy[i] still reads 1 if the same cycle also has mark=1 to that address.
REQ-029 When REG_FILE_BYPASS_EN is undefined, reads return pre-write contents and the pre-write pending state until the next posedge.

Structure
REQ-030 Shared package reg_file_pkg holds the default constants RF_WIDTH=32, RF_DEPTH=32 and RF_NUM_RD=2, plus the typedef rf_addr_t.
REQ-031 One sub-module, reg_file_rd_port, instanced NUM_RD times via generate, implements the read mux, the zero-register override and the optional bypass for a single port.

Verification
REQ-032 Reset with all registers preloaded -> every raddr reads 0, rbusy=0.
REQ-033 we=1, waddr=5, wdata=32'hDEADBEEF; next cycle raddr[0]=5, raddr[1]=5 -> both ports read 32'hDEADBEEF.
REQ-034 we=1, waddr=0, wdata=32'hFFFFFFFF; mark to 0 -> reg 0 reads 0, rbusy=0.
REQ-035 mark=1, mark_addr=7 -> rbusy=1 next cycle. A later we to 7 with wdata=32'h12 -> rbusy=0 and data 32'h12. Same-cycle mark+we to 7 -> rbusy stays 1.
REQ-036 With REG_FILE_BYPASS_EN, we=1, waddr=3, wdata=32'hA5A5A5A5 and raddr[0]=3 in the same cycle -> rdata[0]=32'hA5A5A5A5 that cycle. Without the macro -> old value that cycle.
REQ-037 Write to reg 9 with res=0 in the same cycle -> reg 9 reads 0 afterwards. Parameter sweep WIDTH=8, DEPTH=4, NUM_RD=3 passes REQ-033 to REQ-035.
